// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencing and hazard control: start gating, load-use stall, branch squash, memory freeze and halt drain.
// Optional perf counters are enabled by defining PIPE_HAZARD_CTRL_PERF_CNT_EN.
module pipe_hazard_ctrl #(
  parameter int CNT_W        = 32,
  parameter int DRAIN_CYCLES = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [4:0]       id_rs1_i,
  input  logic [4:0]       id_rs2_i,
  input  logic             id_branch_i,
  input  logic             id_taken_i,
  input  logic             id_halt_i,
  input  logic             ex_memread_i,
  input  logic [4:0]       ex_rd_i,
  input  logic             mem_req_i,
  input  logic             mem_ack_i,
  output logic             pc_write_o,
  output logic             ifid_write_o,
  output logic             ifid_flush_o,
  output logic             idex_nop_o,
  output logic             pipe_hold_o,
  output logic             busy_o,
  output logic             done_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o
);

  localparam int DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RUN,
    S_WAIT,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t        state_q, state_d;
  logic [DW-1:0] drn_q, drn_d;
  logic          lu, mw, br_tk, frz;

  assign lu    = ex_memread_i && (ex_rd_i != 5'd0) &&
                 ((ex_rd_i == id_rs1_i) || (ex_rd_i == id_rs2_i));
  assign mw    = mem_req_i && !mem_ack_i;
  assign br_tk = id_branch_i && id_taken_i;
  // MEM_WAIT keeps the pipe frozen until the ack cycle itself
  assign frz   = (state_q == S_RUN)  ? mw :
                 (state_q == S_WAIT) ? !mem_ack_i : 1'b0;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= S_IDLE;
      drn_q   <= '0;
    end else begin
      state_q <= state_d;
      drn_q   <= drn_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    drn_d        = drn_q;
    pc_write_o   = 1'b0;
    ifid_write_o = 1'b0;
    ifid_flush_o = 1'b0;
    idex_nop_o   = 1'b1;
    pipe_hold_o  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start_i) state_d = S_RUN;
      end
      S_RUN, S_WAIT: begin
        if (frz) begin
          idex_nop_o  = 1'b0;
          pipe_hold_o = 1'b1;
        end else if (lu) begin
          idex_nop_o  = 1'b1;
        end else if (br_tk) begin
          pc_write_o   = 1'b1;
          ifid_write_o = 1'b1;
          ifid_flush_o = 1'b1;
          idex_nop_o   = 1'b0;
        end else begin
          pc_write_o   = 1'b1;
          ifid_write_o = 1'b1;
          idex_nop_o   = 1'b0;
        end
        if (state_q == S_WAIT) begin
          if (mem_ack_i) state_d = S_RUN;
        end else if (mw) begin
          state_d = S_WAIT;
        end else if (id_halt_i && !lu) begin
          state_d = S_DRAIN;
          drn_d   = DW'(DRAIN_CYCLES - 1);
        end
      end
      S_DRAIN: begin
        ifid_flush_o = 1'b1;
        ifid_write_o = !mw;
        pipe_hold_o  = mw;
        if (!mw) begin
          if (drn_q == '0) state_d = S_DONE;
          else             drn_d   = drn_q - DW'(1);
        end
      end
      S_DONE: begin
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign busy_o = (state_q == S_RUN) || (state_q == S_WAIT) ||
                  (state_q == S_DRAIN);
  assign done_o = (state_q == S_DONE);

`ifdef PIPE_HAZARD_CTRL_PERF_CNT_EN
  logic [CNT_W-1:0] stall_q, flush_q;
  logic             stall_ev, flush_ev;

  assign stall_ev = (state_q == S_RUN) && !mw && lu;
  assign flush_ev = (state_q == S_RUN) && !mw && !lu && br_tk;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      if (stall_ev) stall_q <= stall_q + CNT_W'(1);
      if (flush_ev) flush_q <= flush_q + CNT_W'(1);
    end
  end

  assign stall_cnt_o = stall_q;
  assign flush_cnt_o = flush_q;
`else
  assign stall_cnt_o = '0;
  assign flush_cnt_o = '0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Randomized and directed bench for pipe_hazard_ctrl against a behavioural model.
module tb_pipe_hazard_ctrl;
  localparam int CNT_W = 32;
  localparam int DRAIN = 4;
`ifdef PIPE_HAZARD_CTRL_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  localparam int M_IDLE  = 0;
  localparam int M_RUN   = 1;
  localparam int M_WAIT  = 2;
  localparam int M_DRAIN = 3;
  localparam int M_DONE  = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start = 1'b0;
  logic [4:0] rs1 = '0, rs2 = '0, exrd = '0;
  logic br = 0, tk = 0, halt = 0, memrd = 0, req = 0, ack = 0;
  logic pcw, ifw, ifl, nop, hold, busy, done;
  logic [CNT_W-1:0] scnt, fcnt;

  int checks = 0;
  int errors = 0;
  int mode = M_IDLE;
  int drain_left = 0;
  logic [CNT_W-1:0] m_stall = '0, m_flush = '0;

  pipe_hazard_ctrl #(.CNT_W(CNT_W), .DRAIN_CYCLES(DRAIN)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start),
    .id_rs1_i(rs1), .id_rs2_i(rs2),
    .id_branch_i(br), .id_taken_i(tk), .id_halt_i(halt),
    .ex_memread_i(memrd), .ex_rd_i(exrd),
    .mem_req_i(req), .mem_ack_i(ack),
    .pc_write_o(pcw), .ifid_write_o(ifw), .ifid_flush_o(ifl),
    .idex_nop_o(nop), .pipe_hold_o(hold),
    .busy_o(busy), .done_o(done),
    .stall_cnt_o(scnt), .flush_cnt_o(fcnt)
  );

  always #5 clk = ~clk;

  task automatic chk(string tag, logic [CNT_W-1:0] obs,
                     logic [CNT_W-1:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h t=%0t",
             tag, obs, expv, $time);
    end
  endtask

  function automatic bit hazard();
    return memrd && (exrd != 0) && (exrd == rs1 || exrd == rs2);
  endfunction

  task automatic model_reset();
    mode    = M_IDLE;
    m_stall = '0;
    m_flush = '0;
  endtask

  task automatic check_all();
    bit mw, lu, e_pc, e_ifw, e_fl, e_nop, e_hold, chk_ifw;
    mw = req && !ack;
    lu = hazard();
    e_pc = 0; e_ifw = 0; e_fl = 0; e_nop = 1; e_hold = 0; chk_ifw = 1;
    if (mode == M_RUN || mode == M_WAIT) begin
      if ((mode == M_RUN && mw) || (mode == M_WAIT && !ack)) begin
        e_nop = 0; e_hold = 1;
      end else if (lu) begin
        e_nop = 1;
      end else if (br && tk) begin
        e_pc = 1; e_ifw = 1; e_fl = 1; e_nop = 0;
      end else begin
        e_pc = 1; e_ifw = 1; e_nop = 0;
      end
    end else if (mode == M_DRAIN) begin
      e_fl = 1; e_hold = mw; chk_ifw = 0;
    end
    chk("pc_write", pcw, e_pc);
    if (chk_ifw) chk("ifid_write", ifw, e_ifw);
    chk("ifid_flush", ifl, e_fl);
    chk("idex_nop", nop, e_nop);
    chk("pipe_hold", hold, e_hold);
    chk("busy", busy, mode == M_RUN || mode == M_WAIT || mode == M_DRAIN);
    chk("done", done, mode == M_DONE);
    chk("stall_cnt", scnt, PERF ? m_stall : '0);
    chk("flush_cnt", fcnt, PERF ? m_flush : '0);
  endtask

  task automatic advance();
    bit mw, lu;
    mw = req && !ack;
    lu = hazard();
    @(posedge clk);
    if (rst) begin
      case (mode)
        M_IDLE: if (start) mode = M_RUN;
        M_RUN: begin
          if (mw) mode = M_WAIT;
          else begin
            if (lu) m_stall++;
            else if (br && tk) m_flush++;
            if (halt && !lu) begin
              mode = M_DRAIN;
              drain_left = DRAIN;
            end
          end
        end
        M_WAIT: if (ack) mode = M_RUN;
        M_DRAIN: if (!mw) begin
          drain_left--;
          if (drain_left == 0) mode = M_DONE;
        end
        default: ;
      endcase
    end
    @(negedge clk);
  endtask

  task automatic cyc();
    #1 check_all();
    advance();
  endtask

  task automatic clr();
    start = 0; rs1 = 0; rs2 = 0; exrd = 0; br = 0; tk = 0;
    halt = 0; memrd = 0; req = 0; ack = 0;
  endtask

  task automatic do_reset_start();
    @(negedge clk);
    rst = 0; model_reset();
    repeat (2) cyc();
    rst = 1;
    start = 1;
    cyc();
    start = 0;
  endtask

  initial begin
    clr();
    @(negedge clk);
    model_reset();
    repeat (2) cyc();
    rst = 1;
    cyc();
    start = 1; cyc();
    start = 0; cyc();
    // load-use on rs2, then rd=x0 never stalls
    memrd = 1; exrd = 5; rs2 = 5; cyc();
    clr(); cyc();
    memrd = 1; exrd = 0; rs1 = 0; rs2 = 0; cyc();
    clr(); cyc();
    br = 1; tk = 1; cyc();
    clr(); cyc();
    br = 1; tk = 1; memrd = 1; exrd = 7; rs1 = 7; cyc();
    clr(); cyc();
    req = 1; ack = 0; repeat (3) cyc();
    ack = 1; cyc();
    clr(); cyc();
    for (int i = 0; i < 400; i++) begin
      rs1 = 5'($urandom_range(0, 3));
      rs2 = 5'($urandom_range(0, 3));
      exrd = 5'($urandom_range(0, 3));
      memrd = 1'($urandom_range(0, 1));
      br = 1'($urandom_range(0, 1));
      tk = 1'($urandom_range(0, 1));
      start = 1'($urandom_range(0, 1));
      req = (mode == M_WAIT) ? 1'b1 : ($urandom_range(0, 3) == 0);
      ack = 1'($urandom_range(0, 1));
      cyc();
    end
    clr();
    for (int i = 0; i < 8 && mode != M_RUN; i++) begin
      req = 1; ack = 1; cyc();
    end
    clr();
    halt = 1; cyc();
    halt = 0; repeat (DRAIN) cyc();
    repeat (2) cyc();
    do_reset_start();
    br = 1; tk = 1; cyc();
    clr();
    halt = 1; cyc();
    halt = 0; cyc();
    req = 1; ack = 0; repeat (2) cyc();
    ack = 1; cyc();
    clr(); repeat (4) cyc();
    do_reset_start();
    memrd = 1; exrd = 3; rs1 = 3; cyc();
    clr();
    req = 1; ack = 0; repeat (2) cyc();
    rst = 0; model_reset();
    #1 check_all();
    @(negedge clk);
    clr();
    cyc();
    rst = 1;
    cyc();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
